// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer in front of the IF stage: issues in-order word fetches,
// buffers up to DEPTH {instr, pc} entries and flushes on an EX-stage redirect.
module fetch_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pcplus4
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW-1:0] inflight_next;
    logic [CW:0]   occupancy;
    logic [31:0]   redirect_aligned;
    logic          req_fire;
    logic          rsp_take;
    logic          push;
    logic          pop;

    assign occupancy        = {1'b0, count} + {1'b0, inflight};
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};

    assign imem_req_valid = reset && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    assign imem_req_addr  = {fetch_pc[31:2], 2'b00};

    assign req_fire = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding belongs to a pre-reset request and is ignored.
    assign rsp_take = imem_rsp_valid && (inflight != '0);
    assign push     = rsp_take && (drop == '0) && !redirect_valid;
    assign pop      = instr_valid && !stall && !redirect_valid;

    assign inflight_next = inflight + CW'(req_fire) - CW'(rsp_take);

    assign instr_valid   = (count != '0);
    assign instr         = instr_q[rd_ptr];
    assign instr_pc      = pc_q[rd_ptr];
    assign instr_pcplus4 = pc_q[rd_ptr] + 32'd4;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirect_valid) begin
                // Everything still outstanding was fetched down the wrong path.
                fetch_pc <= redirect_aligned;
                rsp_pc   <= redirect_aligned;
                count    <= '0;
                drop     <= inflight_next;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (rsp_take && (drop != '0))
                    drop <= drop - CW'(1);
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            instr_q[wr_ptr] <= imem_rsp_data;
            pc_q[wr_ptr]    <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for fetch_prefetch_buffer: random stall/redirect/ready/latency against a queue-based
// model of the instruction stream IF should observe.
module tb_fetch_prefetch_buffer;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;

  // Handshakes: a request transfers on a rising edge where imem_req_valid && imem_req_ready;
  // a response transfers on any rising edge with imem_rsp_valid; IF consumes the head on an
  // edge with instr_valid && !stall && !redirect_valid.
  fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_pcplus4(instr_pcplus4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        arrived;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        stale;
    int          due;
  } pend_t;

  exp_t        exp_q[$];   // accepted on the current path, not yet consumed by IF
  pend_t       pend_q[$];  // requests the memory still owes a response for
  logic [31:0] model_pc;
  int          cyc;
  int          errors;
  int          checks;
  bit          mon_en;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC0DE_0013;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (pend_q[k]) if (pend_q[k].stale) n++;
    return n;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset          = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      @(posedge clk);
      exp_q.delete();
      pend_q.delete();
      model_pc = RESET_PC;
      cyc++;
    end
  endtask

  task automatic run_cycles(input int n, input int p_stall, input int p_ready,
                            input int p_redir, input int lat_lo, input int lat_hi,
                            input int p_rsp);
    bit   req_fire;
    bit   rsp_fire;
    bit   redir;
    bit   found;
    pend_t p;
    logic [31:0] target;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset          = 1'b1;
      stall          = ($urandom_range(0, 99) < p_stall);
      imem_req_ready = ($urandom_range(0, 99) < p_ready);
      redirect_valid = ($urandom_range(0, 99) < p_redir);
      if ($urandom_range(0, 3) == 0)
        target = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      else
        target = $urandom & 32'h0000_3FFF;
      redirect_pc = target;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc && $urandom_range(0, 99) < p_rsp) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_q[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      #1;
      req_fire = imem_req_valid && imem_req_ready;
      rsp_fire = imem_rsp_valid;
      redir    = redirect_valid;
      @(posedge clk);
      if (rsp_fire) begin
        p = pend_q.pop_front();
        if (!p.stale && !redir) begin
          found = 1'b0;
          foreach (exp_q[k]) begin
            if (!found && !exp_q[k].arrived) begin
              exp_q[k].arrived = 1'b1;
              found = 1'b1;
            end
          end
        end
      end
      if (req_fire) begin
        pend_q.push_back('{addr: model_pc, stale: 1'b0,
                           due: cyc + $urandom_range(lat_lo, lat_hi)});
        exp_q.push_back('{pc: model_pc, data: mem_word(model_pc), arrived: 1'b0});
        model_pc = model_pc + 32'd4;
      end
      if (redir) begin
        exp_q.delete();
        foreach (pend_q[k]) pend_q[k].stale = 1'b1;
        model_pc = {target[31:2], 2'b00};
      end
      cyc++;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    bit exp_req_valid;
    bit exp_instr_valid;
    #2;
    if (mon_en) begin
      exp_req_valid   = reset && !redirect_valid && (exp_q.size() + stale_cnt() < DEPTH);
      exp_instr_valid = (exp_q.size() > 0) && exp_q[0].arrived;
      check32("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req_valid});
      if (exp_req_valid)
        check32("req_addr", imem_req_addr, model_pc);
      check32("instr_valid", {31'b0, instr_valid}, {31'b0, exp_instr_valid});
      if (exp_instr_valid) begin
        check32("instr_pc", instr_pc, exp_q[0].pc);
        check32("instr", instr, exp_q[0].data);
        check32("instr_pcplus4", instr_pcplus4, exp_q[0].pc + 32'd4);
        if (reset && !stall && !redirect_valid)
          void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    mon_en = 1'b0;
    model_pc = RESET_PC;
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

    reset_cycles(1);
    mon_en = 1'b1;
    reset_cycles(1);

    // streaming, 1-cycle memory
    run_cycles(20, 0, 100, 0, 1, 1, 100);
    // stall until the buffer is full, release for one cycle, stall again
    run_cycles(10, 100, 100, 0, 1, 1, 100);
    run_cycles(1, 0, 100, 0, 1, 1, 100);
    run_cycles(6, 100, 100, 0, 1, 1, 100);
    // latency 3 then a redirect with requests in flight
    run_cycles(3, 0, 100, 0, 3, 3, 100);
    run_cycles(3, 100, 100, 0, 3, 3, 100);
    run_cycles(1, 0, 100, 100, 3, 3, 100);
    run_cycles(20, 0, 100, 0, 3, 3, 100);
    // memory back-pressure
    run_cycles(5, 0, 0, 0, 1, 1, 100);
    run_cycles(20, 0, 100, 0, 1, 2, 100);
    // reset while the buffer holds entries
    run_cycles(8, 100, 100, 0, 1, 1, 100);
    reset_cycles(1);
    run_cycles(20, 0, 100, 0, 1, 1, 100);
    // back-to-back redirects
    run_cycles(4, 0, 100, 100, 1, 3, 100);
    run_cycles(20, 10, 100, 0, 1, 3, 100);
    // mixed random traffic
    run_cycles(600, 30, 70, 8, 1, 4, 70);
    run_cycles(30, 0, 100, 0, 1, 1, 100);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
